edge_detect_multi: RTL and testbench

Parametrised multi-channel edge detector for the serial-bus front end (SCL/SDA and similar slow pins).

---
 rtl/edge_detect_pkg.sv | 15 +
 rtl/edge_detect_chan.sv | 76 +++++++
 rtl/edge_detect_multi.sv | 43 ++++
 tb/tb_edge_detect_multi.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared defaults and helpers for the multi-channel serial-line edge detector.
// The filter treats lengths 0 and 1 identically (no filtering).
package edge_detect_pkg;

  localparam int   DEF_NUM_CH      = 2;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_FILT_W      = 3;
  localparam logic DEF_IDLE_LVL    = 1'b1;

  // Effective filter length: number of consecutive mismatching samples needed.
  function automatic int unsigned eff_len(input int unsigned filt_len);
    return (filt_len < 2) ? 1 : filt_len;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One input channel: synchroniser chain, run-time glitch filter, edge pulses
// and a sticky edge flag with software clear.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILT_W      = DEF_FILT_W,
  parameter logic IDLE_LVL    = DEF_IDLE_LVL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              flag_clr,
  output logic              level_out,
  output logic              rising_edge_found,
  output logic              falling_edge_found,
  output logic              edge_flag
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_out;
  logic                   filt_reg;
  logic                   filt_next;
  logic                   prev_reg;
  logic                   flag_reg;
  logic                   flag_next;
  logic [FILT_W-1:0]      cnt_reg;
  logic [FILT_W-1:0]      cnt_next;
  logic [FILT_W-1:0]      eff_m1;
  logic                   rising;
  logic                   falling;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign eff_m1   = FILT_W'(eff_len(32'(filt_len)) - 32'd1);

  // The >= compare lets a shortened filter length accept a pending level at once.
  always_comb begin
    filt_next = filt_reg;
    cnt_next  = cnt_reg;
    if (sync_out == filt_reg) begin
      cnt_next = '0;
    end else if (cnt_reg >= eff_m1) begin
      filt_next = sync_out;
      cnt_next  = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign rising    = filt_reg & ~prev_reg;
  assign falling   = ~filt_reg & prev_reg;
  assign flag_next = (flag_reg & ~flag_clr) | rising | falling;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{IDLE_LVL}};
      filt_reg <= IDLE_LVL;
      prev_reg <= IDLE_LVL;
      cnt_reg  <= '0;
      flag_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      filt_reg <= filt_next;
      prev_reg <= filt_reg;
      cnt_reg  <= cnt_next;
      flag_reg <= flag_next;
    end
  end

  assign level_out          = filt_reg;
  assign rising_edge_found  = rising;
  assign falling_edge_found = falling;
  assign edge_flag          = flag_reg;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector for slow serial-bus pins; every channel is an
// independent edge_detect_chan sharing the filter length setting.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int   NUM_CH      = DEF_NUM_CH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILT_W      = DEF_FILT_W,
  parameter logic IDLE_LVL    = DEF_IDLE_LVL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [NUM_CH-1:0] flag_clr,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rising_edge_found,
  output logic [NUM_CH-1:0] falling_edge_found,
  output logic [NUM_CH-1:0] edge_flag
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      edge_detect_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W),
        .IDLE_LVL    (IDLE_LVL)
      ) u_chan (
        .clk                (clk),
        .rst                (rst),
        .sig_in             (sig_in[gi]),
        .filt_len           (filt_len),
        .flag_clr           (flag_clr[gi]),
        .level_out          (level_out[gi]),
        .rising_edge_found  (rising_edge_found[gi]),
        .falling_edge_found (falling_edge_found[gi]),
        .edge_flag          (edge_flag[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios plus random traffic, all
// compared against a sample-history reference model of the filter rules.
module tb_edge_detect_multi;

  localparam int   NUM_CH      = 2;
  localparam int   SYNC_STAGES = 2;
  localparam int   FILT_W      = 3;
  localparam logic IDLE_LVL    = 1'b1;
  localparam int   HIST_MAX    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] sig_in;
  logic [FILT_W-1:0] filt_len;
  logic [NUM_CH-1:0] flag_clr;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] rising_edge_found;
  logic [NUM_CH-1:0] falling_edge_found;
  logic [NUM_CH-1:0] edge_flag;

  int checks = 0;
  int errors = 0;

  // Reference model: raw samples delayed by the synchroniser depth, and the
  // history of synchronised samples since reset used to find mismatch runs.
  logic [NUM_CH-1:0] m_filt, m_prev, m_flag;
  logic [NUM_CH-1:0] rawq[$];
  logic [NUM_CH-1:0] hist[$];

  edge_detect_multi #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W),
    .IDLE_LVL    (IDLE_LVL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sig_in             (sig_in),
    .filt_len           (filt_len),
    .flag_clr           (flag_clr),
    .level_out          (level_out),
    .rising_edge_found  (rising_edge_found),
    .falling_edge_found (falling_edge_found),
    .edge_flag          (edge_flag)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [NUM_CH-1:0] fs, rise, fall;
    int eff, run;
    if (rst) begin
      m_filt = {NUM_CH{IDLE_LVL}};
      m_prev = {NUM_CH{IDLE_LVL}};
      m_flag = '0;
      rawq.delete();
      repeat (SYNC_STAGES) rawq.push_back({NUM_CH{IDLE_LVL}});
      hist.delete();
    end else begin
      fs = rawq.pop_front();
      rawq.push_back(sig_in);
      rise   = m_filt & ~m_prev;
      fall   = ~m_filt & m_prev;
      m_flag = (m_flag & ~flag_clr) | rise | fall;
      m_prev = m_filt;
      hist.push_back(fs);
      if (hist.size() > HIST_MAX) void'(hist.pop_front());
      eff = (int'(filt_len) < 2) ? 1 : int'(filt_len);
      for (int c = 0; c < NUM_CH; c++) begin
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i][c] == m_filt[c]) break;
          run++;
        end
        if (run >= eff) m_filt[c] = fs[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [4*NUM_CH-1:0] dut_vec();
    return {level_out, rising_edge_found, falling_edge_found, edge_flag};
  endfunction

  function automatic logic [4*NUM_CH-1:0] exp_vec();
    return {m_filt, m_filt & ~m_prev, ~m_filt & m_prev, m_flag};
  endfunction

  task automatic test_reset();
    rst = 1'b1; sig_in = '0; filt_len = '0; flag_clr = '0;
    repeat (3) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_model got %h exp %h", dut_vec(), exp_vec());
      end
      checks++;
      if (level_out !== 2'b11 || rising_edge_found !== 2'b00 || falling_edge_found !== 2'b00) begin
        errors++; $display("FAIL reset_idle got lvl=%b r=%b f=%b exp lvl=11 r=00 f=00",
                           level_out, rising_edge_found, falling_edge_found);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_release_model got %h exp %h", dut_vec(), exp_vec());
      end
      checks++;
      if (falling_edge_found !== ((i == 2) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL reset_fall_pulse cyc=%0d got %b exp %b", i, falling_edge_found,
                           (i == 2) ? 2'b11 : 2'b00);
      end
    end
    checks++;
    if (edge_flag !== 2'b11) begin
      errors++; $display("FAIL reset_flag got %b exp 11", edge_flag);
    end
  endtask

  task automatic test_latency();
    sig_in = 2'b11; flag_clr = 2'b11; filt_len = '0;
    repeat (6) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lat_settle got %h exp %h", dut_vec(), exp_vec());
      end
    end
    flag_clr = '0; sig_in = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL lat_model got %h exp %h", dut_vec(), exp_vec());
      end
      checks++;
      if (falling_edge_found !== ((i == 2) ? 2'b01 : 2'b00) || rising_edge_found !== 2'b00) begin
        errors++; $display("FAIL lat_fall cyc=%0d got f=%b r=%b exp f=%b r=00", i,
                           falling_edge_found, rising_edge_found, (i == 2) ? 2'b01 : 2'b00);
      end
    end
    checks++;
    if (level_out !== 2'b10) begin
      errors++; $display("FAIL lat_level got %b exp 10", level_out);
    end
  endtask

  task automatic test_glitch_filter();
    int nf, nr, low_seen, fall_at, rise_at;
    filt_len = 3'd4; sig_in = 2'b11; flag_clr = 2'b11;
    repeat (8) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL glitch_settle got %h exp %h", dut_vec(), exp_vec());
      end
    end
    flag_clr = '0;
    nf = 0; low_seen = 0;
    for (int i = 0; i < 12; i++) begin
      sig_in[1] = (i < 3) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL glitch_model got %h exp %h", dut_vec(), exp_vec());
      end
      nf += int'(falling_edge_found[1]);
      low_seen += int'(!level_out[1]);
    end
    checks++;
    if (nf != 0 || low_seen != 0) begin
      errors++; $display("FAIL glitch_suppress got pulses=%0d low_cycles=%0d exp 0 0", nf, low_seen);
    end
    nf = 0; nr = 0; fall_at = -1; rise_at = -1;
    for (int i = 0; i < 16; i++) begin
      sig_in[1] = (i < 4) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL glitch_pass_model got %h exp %h", dut_vec(), exp_vec());
      end
      if (falling_edge_found[1]) begin nf++; fall_at = i; end
      if (rising_edge_found[1])  begin nr++; rise_at = i; end
    end
    checks++;
    if (nf != 1 || fall_at != 5 || nr != 1 || rise_at != 9) begin
      errors++; $display("FAIL glitch_pass got fall=%0d@%0d rise=%0d@%0d exp fall=1@5 rise=1@9",
                         nf, fall_at, nr, rise_at);
    end
  endtask

  task automatic test_set_wins();
    filt_len = '0; sig_in = 2'b00; flag_clr = 2'b11;
    repeat (6) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL sw_settle got %h exp %h", dut_vec(), exp_vec());
      end
    end
    flag_clr = '0; sig_in = 2'b11;
    repeat (3) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL sw_model got %h exp %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (rising_edge_found !== 2'b11) begin
      errors++; $display("FAIL sw_rise got %b exp 11", rising_edge_found);
    end
    flag_clr = 2'b11;
    tick();
    checks++;
    if (edge_flag !== 2'b11) begin
      errors++; $display("FAIL sw_set_wins got %b exp 11", edge_flag);
    end
    flag_clr = 2'b01;
    tick();
    checks++;
    if (edge_flag !== 2'b10 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL sw_partial_clr got flag=%b vec=%h exp flag=10 vec=%h",
                         edge_flag, dut_vec(), exp_vec());
    end
    flag_clr = '0;
  endtask

  task automatic test_filt_len_change();
    int nf;
    filt_len = 3'd7; sig_in = 2'b11; flag_clr = 2'b11;
    repeat (10) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL flc_settle got %h exp %h", dut_vec(), exp_vec());
      end
    end
    flag_clr = '0; sig_in = 2'b10;
    repeat (5) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || falling_edge_found !== 2'b00) begin
        errors++; $display("FAIL flc_wait got %h exp %h", dut_vec(), exp_vec());
      end
    end
    filt_len = 3'd2;
    tick();
    checks++;
    if (falling_edge_found !== 2'b01 || level_out !== 2'b10) begin
      errors++; $display("FAIL flc_accept got f=%b lvl=%b exp f=01 lvl=10",
                         falling_edge_found, level_out);
    end
    nf = 0;
    repeat (6) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL flc_model got %h exp %h", dut_vec(), exp_vec());
      end
      nf += int'(falling_edge_found[0]);
    end
    checks++;
    if (nf != 0) begin
      errors++; $display("FAIL flc_single_pulse got extra=%0d exp 0", nf);
    end
  endtask

  task automatic test_reset_mid_filter();
    filt_len = 3'd4; sig_in = 2'b11; flag_clr = 2'b11;
    repeat (8) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rmf_settle got %h exp %h", dut_vec(), exp_vec());
      end
    end
    flag_clr = '0; sig_in = 2'b10;
    repeat (5) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rmf_count got %h exp %h", dut_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (level_out !== 2'b11 || falling_edge_found !== 2'b00 || edge_flag !== 2'b00) begin
      errors++; $display("FAIL rmf_reset got lvl=%b f=%b flag=%b exp lvl=11 f=00 flag=00",
                         level_out, falling_edge_found, edge_flag);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL rmf_model got %h exp %h", dut_vec(), exp_vec());
      end
      checks++;
      if (falling_edge_found[0] !== (i == 5)) begin
        errors++; $display("FAIL rmf_fall cyc=%0d got %b exp %b", i, falling_edge_found[0], i == 5);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 5) == 0) sig_in[c] = ~sig_in[c];
      if ($urandom_range(0, 39) == 0) filt_len = FILT_W'($urandom_range(0, 7));
      flag_clr = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom_range(0, 3)) : '0;
      rst = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch_filter();
    test_set_wins();
    test_filt_len_change();
    test_reset_mid_filter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
